// File: rtl/memory_arbiter_if.sv
// Requester-side bus of the memory arbiter: one instance per requesting port.
// The requester drives the master modport; the arbiter uses the slave modport.
interface memory_arbiter_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16
) ();
    logic                     request;
    logic                     write_enable;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    write_data;
    logic                     acknowledge;
    logic [DATA_WIDTH-1:0]    read_data;

    modport master (
        output request, write_enable, address, write_data,
        input  acknowledge, read_data
    );

    modport slave (
        input  request, write_enable, address, write_data,
        output acknowledge, read_data
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between two requesters,
// sequencing each access through IDLE -> ISSUE -> (WAIT) -> RESPOND.
module memory_arbiter #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    memory_arbiter_if.slave          port0,
    memory_arbiter_if.slave          port1,
    input  logic [DATA_WIDTH-1:0]    memory_read_data,
    output logic                     memory_write_enable,
    output logic [ADDRESS_WIDTH-1:0] memory_address,
    output logic [DATA_WIDTH-1:0]    memory_write_data,
    output logic                     busy,
    output logic                     owner
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] RESPOND = 2'd3;

    localparam logic [1:0] LATENCY_LOAD = 2'(READ_LATENCY);

    logic [1:0]               state_r;
    logic [1:0]               state_nxt_s;
    logic                     grant_s;
    logic                     capture_s;
    logic                     grant_port_s;
    logic                     grant_we_s;
    logic [ADDRESS_WIDTH-1:0] grant_addr_s;
    logic [DATA_WIDTH-1:0]    grant_wdata_s;

    logic                     owner_r;
    logic                     last_owner_r;
    logic                     we_r;
    logic [ADDRESS_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0]    wdata_r;
    logic [1:0]               cnt_r;
    logic                     mem_we_r;
    logic                     ack0_r;
    logic                     ack1_r;
    logic                     busy_r;
    logic [DATA_WIDTH-1:0]    rdata0_r;
    logic [DATA_WIDTH-1:0]    rdata1_r;

    // Arbitration: a tie goes to the port that did not own the previous access.
    always_comb begin
        grant_port_s = 1'b0;
        if (port0.request && port1.request) begin
            grant_port_s = ~last_owner_r;
        end else if (port1.request) begin
            grant_port_s = 1'b1;
        end else begin
            grant_port_s = 1'b0;
        end
        grant_we_s    = grant_port_s ? port1.write_enable : port0.write_enable;
        grant_addr_s  = grant_port_s ? port1.address      : port0.address;
        grant_wdata_s = grant_port_s ? port1.write_data   : port0.write_data;
    end

    // Next-state logic; capture_s marks the edge where the wait counter hits zero.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (port0.request || port1.request) begin
                    grant_s     = 1'b1;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (we_r) begin
                    state_nxt_s = RESPOND;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == 2'd1) begin
                    capture_s   = 1'b1;
                    state_nxt_s = RESPOND;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESPOND: state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latch the granted request; these registers also drive the memory bus and hold afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            we_r         <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
        end else if (grant_s) begin
            owner_r      <= grant_port_s;
            last_owner_r <= grant_port_s;
            we_r         <= grant_we_s;
            addr_r       <= grant_addr_s;
            wdata_r      <= grant_wdata_s;
        end
    end

    // Read-latency counter: loaded in ISSUE, counts down through WAIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= 2'd0;
        end else if (state_r == ISSUE) begin
            cnt_r <= LATENCY_LOAD;
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r - 2'd1;
        end
    end

    // Read data is captured only into the owning port; the other port keeps its last result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata0_r <= '0;
            rdata1_r <= '0;
        end else if (capture_s) begin
            if (owner_r) begin
                rdata1_r <= memory_read_data;
            end else begin
                rdata0_r <= memory_read_data;
            end
        end
    end

    // Status outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_we_r <= 1'b0;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            mem_we_r <= grant_s & grant_we_s;
            ack0_r   <= (state_nxt_s == RESPOND) & ~owner_r;
            ack1_r   <= (state_nxt_s == RESPOND) & owner_r;
            busy_r   <= (state_nxt_s != IDLE);
        end
    end

    assign memory_write_enable = mem_we_r;
    assign memory_address      = addr_r;
    assign memory_write_data   = wdata_r;
    assign busy                = busy_r;
    assign owner               = owner_r;
    assign port0.acknowledge   = ack0_r;
    assign port0.read_data     = rdata0_r;
    assign port1.acknowledge   = ack1_r;
    assign port1.read_data     = rdata1_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: instance 0 uses READ_LATENCY=1, instance 1 uses 3.
// Stimulus pushes expected acknowledges and write strobes; per-instance monitors pop and compare.
module tb_memory_arbiter;

    typedef struct {
        logic        port;
        logic        is_rd;
        logic [15:0] data;
        int          cyc;
    } item_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    item_t exp_q [2][$];
    wr_t   wr_q  [2][$];

    logic [1:0]       req0, we0, req1, we1;
    logic [1:0][15:0] addr0, wd0, addr1, wd1;
    logic [1:0]       ack0_o, ack1_o, busy_o, owner_o, mwe_o;
    logic [1:0][15:0] rd0_o, rd1_o, maddr_o, mwd_o;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic int rl(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int RL = (g == 0) ? 1 : 3;

        memory_arbiter_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16)) p0 ();
        memory_arbiter_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16)) p1 ();

        logic [15:0] mem  [256];
        logic [15:0] pipe [3];
        logic [15:0] mrd;
        logic [15:0] m_rd0, m_rd1;

        assign p0.request      = req0[g];
        assign p0.write_enable = we0[g];
        assign p0.address      = addr0[g];
        assign p0.write_data   = wd0[g];
        assign p1.request      = req1[g];
        assign p1.write_enable = we1[g];
        assign p1.address      = addr1[g];
        assign p1.write_data   = wd1[g];
        assign ack0_o[g]       = p0.acknowledge;
        assign ack1_o[g]       = p1.acknowledge;
        assign rd0_o[g]        = p0.read_data;
        assign rd1_o[g]        = p1.read_data;
        assign mrd             = pipe[RL-1];

        memory_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .READ_LATENCY(RL)) dut (
            .clock               (clock),
            .reset               (reset),
            .port0               (p0),
            .port1               (p1),
            .memory_read_data    (mrd),
            .memory_write_enable (mwe_o[g]),
            .memory_address      (maddr_o[g]),
            .memory_write_data   (mwd_o[g]),
            .busy                (busy_o[g]),
            .owner               (owner_o[g])
        );

        // Synchronous memory: unwritten word at address a reads as {8'hC0, a[7:0]}.
        always @(posedge clock) begin
            if (!reset) begin
                for (int i = 0; i < 256; i++) mem[i] <= {8'hC0, 8'(i)};
            end else if (mwe_o[g]) begin
                mem[maddr_o[g][7:0]] <= mwd_o[g];
            end
            pipe[0] <= mem[maddr_o[g][7:0]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        always @(negedge clock) begin : mon
            item_t it;
            wr_t   w;
            if (!reset) begin
                m_rd0 = 16'h0000;
                m_rd1 = 16'h0000;
            end else begin
                if (mwe_o[g]) begin
                    if (wr_q[g].size() == 0) begin
                        chk("unexpected_write_strobe", 32'(maddr_o[g]), 32'hFFFF_FFFF);
                    end else begin
                        w = wr_q[g].pop_front();
                        chk("strobe_address", 32'(maddr_o[g]), 32'(w.addr));
                        chk("strobe_data", 32'(mwd_o[g]), 32'(w.data));
                    end
                end
                if (ack0_o[g] || ack1_o[g]) begin
                    chk("single_ack", 32'(ack0_o[g] & ack1_o[g]), 32'd0);
                    if (exp_q[g].size() == 0) begin
                        chk("unexpected_ack", 32'(cyc), 32'hFFFF_FFFF);
                    end else begin
                        it = exp_q[g].pop_front();
                        chk("ack_port", 32'(ack1_o[g]), 32'(it.port));
                        chk("owner", 32'(owner_o[g]), 32'(it.port));
                        chk("ack_cycle", 32'(cyc), 32'(it.cyc));
                        if (it.is_rd) begin
                            if (it.port) m_rd1 = it.data;
                            else         m_rd0 = it.data;
                        end
                        chk("read_data0", 32'(rd0_o[g]), 32'(m_rd0));
                        chk("read_data1", 32'(rd1_o[g]), 32'(m_rd1));
                    end
                end
            end
        end
    end

    task automatic push_exp(input int g, input logic port, input logic is_rd,
                            input logic [15:0] data, input int at);
        item_t it;
        it.port  = port;
        it.is_rd = is_rd;
        it.data  = data;
        it.cyc   = at;
        exp_q[g].push_back(it);
    endtask

    task automatic txn(input int g, input logic port, input logic we,
                       input logic [15:0] a, input logic [15:0] d, input logic [15:0] rexp);
        int  c;
        bit  seen;
        wr_t w;
        @(negedge clock);
        c = cyc;
        if (port) begin
            req1[g] = 1'b1; we1[g] = we; addr1[g] = a; wd1[g] = d;
        end else begin
            req0[g] = 1'b1; we0[g] = we; addr0[g] = a; wd0[g] = d;
        end
        push_exp(g, port, !we, rexp, we ? c + 2 : c + 2 + rl(g));
        if (we) begin
            w.addr = a;
            w.data = d;
            wr_q[g].push_back(w);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            seen = port ? ack1_o[g] : ack0_o[g];
        end
        if (!seen) chk("ack_timeout", 32'd0, 32'd1);
        if (port) req1[g] = 1'b0;
        else      req0[g] = 1'b0;
    endtask

    initial begin
        int c;
        int n;
        req0 = '0; we0 = '0; req1 = '0; we1 = '0;
        addr0 = '0; wd0 = '0; addr1 = '0; wd1 = '0;

        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_busy", 32'(busy_o[0]), 32'd0);
        chk("rst_ack0", 32'(ack0_o[0]), 32'd0);
        chk("rst_ack1", 32'(ack1_o[0]), 32'd0);
        chk("rst_mwe", 32'(mwe_o[0]), 32'd0);
        chk("rst_maddr", 32'(maddr_o[0]), 32'd0);
        chk("rst_mwdata", 32'(mwd_o[0]), 32'd0);
        chk("rst_rd0", 32'(rd0_o[0]), 32'd0);
        chk("rst_rd1", 32'(rd1_o[0]), 32'd0);
        chk("rst_owner", 32'(owner_o[0]), 32'd0);
        chk("rst_busy_rl3", 32'(busy_o[1]), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Port 0 write, then port 1 read of the same word.
        txn(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

        // Both ports reading continuously: grants must alternate starting with port 0.
        @(negedge clock);
        c = cyc;
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 16'h0020;
        req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 16'h0031;
        for (int k = 0; k < 6; k++) begin
            push_exp(0, (k % 2) == 1, 1'b1, ((k % 2) == 1) ? 16'hC031 : 16'hC020, c + 3 + k * 4);
        end
        n = 0;
        for (int t = 0; t < 80 && n < 6; t++) begin
            @(negedge clock);
            if (ack0_o[0] || ack1_o[0]) n++;
        end
        if (n != 6) chk("fair_ack_count", 32'(n), 32'd6);
        req0[0] = 1'b0;
        req1[0] = 1'b0;

        // Request dropped during WAIT still completes, and no second access follows.
        @(negedge clock);
        c = cyc;
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 16'h0010;
        push_exp(0, 1'b0, 1'b1, 16'hBEEF, c + 3);
        @(negedge clock);
        @(negedge clock);
        req0[0] = 1'b0;
        repeat (12) @(negedge clock);
        chk("drop_idle_busy", 32'(busy_o[0]), 32'd0);

        // Reset during WAIT of a port 1 read.
        @(negedge clock);
        req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 16'h0031;
        @(negedge clock);
        @(negedge clock);
        chk("busy_before_reset", 32'(busy_o[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_o[0]), 32'd0);
        chk("midrst_ack1", 32'(ack1_o[0]), 32'd0);
        chk("midrst_mwe", 32'(mwe_o[0]), 32'd0);
        chk("midrst_rd0", 32'(rd0_o[0]), 32'd0);
        chk("midrst_rd1", 32'(rd1_o[0]), 32'd0);
        chk("midrst_owner", 32'(owner_o[0]), 32'd0);
        req1[0] = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        txn(0, 1'b1, 1'b1, 16'h0040, 16'h1234, 16'h0000);
        txn(0, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1234);

        // READ_LATENCY = 3 instance.
        txn(1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        txn(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

        repeat (10) @(negedge clock);
        chk("pending_acks_rl1", 32'(exp_q[0].size()), 32'd0);
        chk("pending_acks_rl3", 32'(exp_q[1].size()), 32'd0);
        chk("pending_writes_rl1", 32'(wr_q[0].size()), 32'd0);
        chk("pending_writes_rl3", 32'(wr_q[1].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
